// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and sizing helpers for the gated-clock enable scheduler.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WAKE   = 2'd1,
    ST_BUSY   = 2'd2,
    ST_LINGER = 2'd3
  } state_e;

  // Counter must hold the larger of the two reload values.
  function automatic int unsigned cnt_width(input int unsigned wake_cyc,
                                            input int unsigned idle_cyc);
    int unsigned m;
    m = (wake_cyc > idle_cyc) ? wake_cyc : idle_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_rr_arbiter.sv
// Combinational round-robin select: search starts one past the pointer and wraps.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_idx
);

  logic             w_found;
  logic [PTR_W-1:0] w_sel;
  int               w_k;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sel   = '0;
    w_k     = 0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      w_k   = (int'(i_ptr) + i) % int'(NUM_REQ);
      w_sel = PTR_W'(w_k);
      if (!w_found && i_req[w_sel]) begin
        w_found      = 1'b1;
        o_gnt[w_sel] = 1'b1;
        o_idx        = w_sel;
      end
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-enable scheduler: wakes the gated domain, grants it round-robin, idles it out.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned IDLE_CYC = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               DONE,
  output logic               CLK_EN,
  output logic [NUM_REQ-1:0] GNT,
  output logic               IDLE
);

  localparam int unsigned CNT_W = cnt_width(WAKE_CYC, IDLE_CYC);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic [PTR_W-1:0]   r_ptr, w_ptr_d;
  logic [NUM_REQ-1:0] r_win, w_win_d;
  logic [PTR_W-1:0]   r_win_idx, w_win_idx_d;
  logic               r_clk_en;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_idle;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [PTR_W-1:0]   w_arb_idx;
  logic               w_any_req;

  assign w_any_req = |REQ;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req (REQ),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_ptr_d     = r_ptr;
    w_win_d     = r_win;
    w_win_idx_d = r_win_idx;
    unique case (r_state)
      ST_OFF: begin
        if (w_any_req) begin
          w_state_d = ST_WAKE;
          w_cnt_d   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end else if (w_any_req) begin
          w_state_d   = ST_BUSY;
          w_win_d     = w_arb_gnt;
          w_win_idx_d = w_arb_idx;
        end else begin
          w_state_d = ST_LINGER;
          w_cnt_d   = IDLE_LOAD;
        end
      end
      ST_BUSY: begin
        if (DONE) begin
          w_state_d = ST_LINGER;
          w_cnt_d   = IDLE_LOAD;
          w_ptr_d   = r_win_idx;
          w_win_d   = '0;
        end
      end
      ST_LINGER: begin
        if (w_any_req) begin
          w_state_d   = ST_BUSY;
          w_win_d     = w_arb_gnt;
          w_win_idx_d = w_arb_idx;
        end else if (r_cnt == '0) begin
          w_state_d = ST_OFF;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_OFF;
      r_cnt     <= '0;
      r_ptr     <= PTR_RST;
      r_win     <= '0;
      r_win_idx <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_ptr     <= w_ptr_d;
      r_win     <= w_win_d;
      r_win_idx <= w_win_idx_d;
    end
  end

  // Outputs decode the current state one edge late so CLK_EN is a clean flop output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_clk_en <= 1'b0;
      r_gnt    <= '0;
      r_idle   <= 1'b1;
    end else begin
      r_clk_en <= (r_state != ST_OFF);
      r_gnt    <= (r_state == ST_BUSY) ? r_win : '0;
      r_idle   <= (r_state == ST_OFF);
    end
  end

  assign CLK_EN = r_clk_en;
  assign GNT    = r_gnt;
  assign IDLE   = r_idle;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed scenarios plus randomized traffic against a timing model.
module tb_clk_gate_ctrl;

  localparam int NUM_REQ  = 2;
  localparam int WAKE_CYC = 2;
  localparam int IDLE_CYC = 8;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [NUM_REQ-1:0] REQ = '0;
  logic               DONE = 1'b0;
  logic               CLK_EN;
  logic [NUM_REQ-1:0] GNT;
  logic               IDLE;

  int checks   = 0;
  int failures = 0;

  clk_gate_ctrl #(
    .NUM_REQ  (NUM_REQ),
    .WAKE_CYC (WAKE_CYC),
    .IDLE_CYC (IDLE_CYC)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .DONE   (DONE),
    .CLK_EN (CLK_EN),
    .GNT    (GNT),
    .IDLE   (IDLE)
  );

  always #5 CLK = ~CLK;

  // Model: domain powered flag, remaining wake cycles, current owner, last served, idle run.
  bit                 m_pow;
  int                 m_wake;
  int                 m_owner;
  int                 m_last;
  int                 m_idle;
  logic               exp_clk_en;
  logic [NUM_REQ-1:0] exp_gnt;
  logic               exp_idle;

  function automatic int pick(input logic [NUM_REQ-1:0] req, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (req[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Advance one edge; expected outputs reflect the model as it stood before the edge.
  task automatic tick();
    @(posedge CLK);
    exp_clk_en = m_pow;
    exp_idle   = !m_pow;
    exp_gnt    = '0;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    if (RST) begin
      m_pow = 0; m_wake = 0; m_owner = -1; m_last = NUM_REQ - 1; m_idle = 0;
      exp_clk_en = 1'b0; exp_gnt = '0; exp_idle = 1'b1;
    end else if (m_owner >= 0) begin
      if (DONE) begin
        m_last = m_owner; m_owner = -1; m_idle = 0;
      end
    end else if (!m_pow) begin
      if (|REQ) begin
        m_pow = 1; m_wake = WAKE_CYC;
      end
    end else if (m_wake > 0) begin
      m_wake--;
      if (m_wake == 0) begin
        if (|REQ) m_owner = pick(REQ, m_last);
        else m_idle = 0;
      end
    end else if (|REQ) begin
      m_owner = pick(REQ, m_last);
    end else begin
      m_idle++;
      if (m_idle >= IDLE_CYC) m_pow = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = '0; DONE = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (CLK_EN !== 1'b0) begin failures++; $display("FAIL reset_clk_en got=%b want=0", CLK_EN); end
    checks++;
    if (GNT !== '0) begin failures++; $display("FAIL reset_gnt got=%b want=00", GNT); end
    checks++;
    if (IDLE !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b want=1", IDLE); end
  endtask

  // REQ sampled at edge t: CLK_EN after t+1, GNT after t+1+WAKE_CYC.
  task automatic test_wake();
    REQ = 2'b01;
    tick();
    checks++;
    if (CLK_EN !== 1'b0 || IDLE !== 1'b1) begin
      failures++; $display("FAIL wake_t clk_en=%b idle=%b want 0/1", CLK_EN, IDLE);
    end
    tick();
    checks++;
    if (CLK_EN !== 1'b1 || IDLE !== 1'b0 || GNT !== 2'b00) begin
      failures++; $display("FAIL wake_t1 clk_en=%b idle=%b gnt=%b want 1/0/00", CLK_EN, IDLE, GNT);
    end
    for (int i = 0; i < WAKE_CYC - 1; i++) begin
      tick();
      checks++;
      if (GNT !== 2'b00) begin failures++; $display("FAIL wake_early_gnt got=%b want=00", GNT); end
    end
    tick();
    checks++;
    if (GNT !== 2'b01) begin failures++; $display("FAIL wake_grant got=%b want=01", GNT); end
    REQ = 2'b00;
  endtask

  task automatic test_release();
    tick(); tick();
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    checks++;
    if (GNT !== 2'b01) begin failures++; $display("FAIL release_d got=%b want=01", GNT); end
    tick();
    checks++;
    if (GNT !== 2'b00 || CLK_EN !== 1'b1) begin
      failures++; $display("FAIL release_d1 gnt=%b clk_en=%b want 00/1", GNT, CLK_EN);
    end
    for (int i = 2; i <= IDLE_CYC + 1; i++) begin
      tick();
      checks++;
      if (CLK_EN !== (i <= IDLE_CYC)) begin
        failures++; $display("FAIL release_idle_d+%0d clk_en=%b want=%b", i, CLK_EN, (i <= IDLE_CYC));
      end
    end
    checks++;
    if (IDLE !== 1'b1) begin failures++; $display("FAIL release_off_idle got=%b want=1", IDLE); end
  endtask

  task automatic test_alternate();
    logic [NUM_REQ-1:0] want;
    int n;
    do_reset();
    REQ = 2'b11;
    n = 0;
    while (GNT === '0 && n < 20) begin tick(); n++; end
    checks++;
    if (GNT !== 2'b01) begin failures++; $display("FAIL alt_first got=%b want=01", GNT); end
    want = 2'b10;
    for (int g = 0; g < 4; g++) begin
      tick();
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      tick();
      checks++;
      if (GNT !== 2'b00 || CLK_EN !== 1'b1) begin
        failures++; $display("FAIL alt_gap%0d gnt=%b clk_en=%b want 00/1", g, GNT, CLK_EN);
      end
      tick();
      checks++;
      if (GNT !== want || CLK_EN !== 1'b1) begin
        failures++; $display("FAIL alt_grant%0d gnt=%b clk_en=%b want %b/1", g, GNT, CLK_EN, want);
      end
      want = ~want;
    end
    REQ = 2'b00;
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    for (int i = 0; i < IDLE_CYC + 3; i++) tick();
  endtask

  // Request arriving mid-linger: served without passing through WAKE.
  task automatic test_linger_rerequest();
    int n;
    REQ = 2'b01;
    n = 0;
    while (GNT === '0 && n < 20) begin tick(); n++; end
    checks++;
    if (GNT !== 2'b01) begin failures++; $display("FAIL linger_setup got=%b want=01", GNT); end
    REQ = 2'b00;
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    REQ = 2'b10;
    tick();
    checks++;
    if (GNT !== 2'b00 || CLK_EN !== 1'b1) begin
      failures++; $display("FAIL linger_req_edge gnt=%b clk_en=%b want 00/1", GNT, CLK_EN);
    end
    tick();
    checks++;
    if (GNT !== 2'b10 || CLK_EN !== 1'b1) begin
      failures++; $display("FAIL linger_grant gnt=%b clk_en=%b want 10/1", GNT, CLK_EN);
    end
    REQ = 2'b00;
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    for (int i = 0; i < IDLE_CYC + 3; i++) tick();
  endtask

  task automatic test_pulse_wake();
    checks++;
    if (CLK_EN !== 1'b0) begin failures++; $display("FAIL pulse_pre clk_en=%b want=0", CLK_EN); end
    REQ = 2'b01;
    tick();
    REQ = 2'b00;
    for (int i = 1; i <= WAKE_CYC + IDLE_CYC + 1; i++) begin
      tick();
      checks++;
      if (GNT !== 2'b00 || CLK_EN !== (i <= WAKE_CYC + IDLE_CYC)) begin
        failures++;
        $display("FAIL pulse_t+%0d gnt=%b clk_en=%b want 00/%b", i, GNT, CLK_EN,
                 (i <= WAKE_CYC + IDLE_CYC));
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    int n;
    REQ = 2'b10;
    n = 0;
    while (GNT === '0 && n < 20) begin tick(); n++; end
    checks++;
    if (GNT !== 2'b10) begin failures++; $display("FAIL rstbusy_setup got=%b want=10", GNT); end
    REQ = 2'b11;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (CLK_EN !== 1'b0 || GNT !== 2'b00 || IDLE !== 1'b1) begin
      failures++; $display("FAIL rstbusy_out clk_en=%b gnt=%b idle=%b want 0/00/1", CLK_EN, GNT, IDLE);
    end
    n = 0;
    while (GNT === '0 && n < 20) begin tick(); n++; end
    checks++;
    if (GNT !== 2'b01) begin failures++; $display("FAIL rstbusy_regrant got=%b want=01", GNT); end
    REQ = 2'b00;
  endtask

  task automatic test_random();
    int bad;
    int p_req;
    do_reset();
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      // Alternate dense and sparse traffic so the clock also idles out.
      p_req = ((c / 200) % 2 == 0) ? 30 : 2;
      for (int b = 0; b < NUM_REQ; b++) begin
        if ($urandom_range(99) < p_req) REQ[b] = ~REQ[b];
        else if (p_req < 10 && REQ[b] && $urandom_range(3) == 0) REQ[b] = 1'b0;
      end
      DONE = ($urandom_range(3) == 0);
      RST  = ($urandom_range(499) == 0);
      tick();
      checks++;
      if (CLK_EN !== exp_clk_en || GNT !== exp_gnt || IDLE !== exp_idle) begin
        failures++;
        if (bad < 10) begin
          $display("FAIL random_c%0d clk_en=%b gnt=%b idle=%b want %b/%b/%b", c, CLK_EN, GNT, IDLE,
                   exp_clk_en, exp_gnt, exp_idle);
        end
        bad++;
      end
    end
    RST = 1'b0; DONE = 1'b0; REQ = '0;
  endtask

  initial begin
    m_pow = 0; m_wake = 0; m_owner = -1; m_last = NUM_REQ - 1; m_idle = 0;
    test_reset();
    test_wake();
    test_release();
    test_alternate();
    test_linger_rerequest();
    test_pulse_wake();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
